// File: rtl/exp_sched.sv
// Round-robin front end for the shared, fully pipelined exp datapath.
// Requesters hand operands over valid/ready; one operand per cycle is
// registered onto exp_in, its requester ID travels alongside it through a
// tag pipe, and the result comes back on rsp_* tagged with that ID.
// en/state let software quiesce the datapath before reloading coefficients.
//
// Handshake: a transfer on requester k happens at a rising edge where
// req_valid[k] & req_ready[k]. req_ready is combinational, one-hot, and
// depends only on en, RST, req_valid and the round-robin pointer; a
// requester may drop req_valid while not granted. rsp_valid is a one-cycle
// pulse with no back-pressure.
module exp_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int LAT   = 1,
  parameter int DW    = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       exp_in,
  input  logic [DW-1:0]       exp_out,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [DW-1:0]       rsp_data,
  output logic [3:0]          inflight,
  output logic [1:0]          state,
  output logic                idle
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  // Registered state
  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic [DW-1:0]              exp_in_q, exp_in_d;
  // Tag stage 0 is aligned with exp_in; stage LAT is aligned with exp_out.
  logic [LAT:0]               tag_v_q, tag_v_d;
  logic [LAT:0][ID_W-1:0]     tag_id_q, tag_id_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]            rsp_id_q, rsp_id_d;
  logic [DW-1:0]              rsp_data_q, rsp_data_d;
  logic [3:0]                 inflight_q, inflight_d;
  state_t                     state_q, state_d;
  logic                       idle_q, idle_d;

  // Grant search results
  logic                       grant_found;
  logic [ID_W-1:0]            grant_idx;
  logic [ID_W-1:0]            cand;
  logic [DW-1:0]              sel_data;
  logic                       accept;
  logic                       rsp_fire;

  // Round-robin search starting at the pointer; grants follow en, not state.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && en && !RST && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
    end
  end

  // One-hot ready vector and the operand of the granted requester.
  always_comb begin
    req_ready = '0;
    sel_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_found && (grant_idx == ID_W'(k))) begin
        req_ready[k] = 1'b1;
        sel_data     = req_data[k*DW +: DW];
      end
    end
  end

  assign accept   = grant_found;
  assign rsp_fire = tag_v_q[LAT];

  // Next-state logic for pointer, datapath input, tag pipe, response,
  // in-flight count and the enable/drain FSM.
  always_comb begin
    ptr_d    = ptr_q;
    exp_in_d = exp_in_q;
    if (accept) begin
      exp_in_d = sel_data;
      ptr_d    = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
    end

    tag_v_d  = {tag_v_q[LAT-1:0], accept};
    tag_id_d = {tag_id_q[LAT-1:0], grant_idx};

    rsp_valid_d = rsp_fire;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (rsp_fire) begin
      rsp_id_d   = tag_id_q[LAT];
      rsp_data_d = exp_out;
    end

    case ({accept, rsp_fire})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          if ((inflight_q != 4'd0) || (|tag_v_q)) state_d = ST_DRAIN;
          else                                    state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (en)                      state_d = ST_RUN;
        else if (inflight_d == 4'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  // All state flops; reset discards every in-flight tag immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q       <= '0;
      exp_in_q    <= '0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
      state_q     <= ST_IDLE;
      idle_q      <= 1'b1;
    end else begin
      ptr_q       <= ptr_d;
      exp_in_q    <= exp_in_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      inflight_q  <= inflight_d;
      state_q     <= state_d;
      idle_q      <= idle_d;
    end
  end

  assign exp_in    = exp_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign inflight  = inflight_q;
  assign state     = state_q;
  assign idle      = idle_q;

endmodule
